ring_sched: RTL and testbench
=============================

// Module: ring_sched
// PURPOSE
// Sequencer for an N-element systolic ring of proc PEs computing y = A*x. Per job it
//  clears the PE accumulators, loads x_init into the ring, then streams N coefficient
//  steps (fetch address, then PE enable). It then drains the N y results over a
//  valid/ready port. Sits between the host job interface, the coefficient RAM
//  (1-cycle read latency) and the PE array.
// PARAMETERS
// N       4                 number of PEs in the ring = matrix order; N >= 2
// W       16                PE data width (a, x, x_init, y)
// CW      $clog2(N)         width of step/index counters
// PORTS
// clk        in   1     rising-edge clock
// reset      in   1     asynchronous, active-low reset
// start      in   1     job request; sampled only in IDLE
// busy       out  1     high from the cycle after start is accepted until DONE completes
// done       out  1     one-cycle pulse in DONE state
// pe_clr     out  1     clear PE accumulators (CLEAR state only)
// pe_load    out  1     PEs capture x_init (LOAD state only)
// pe_en      out  1     PEs consume coefficient a and rotate x one position
// coef_addr  out  CW    coefficient RAM row address; data valid on a 1 cycle later
// y_sel      out  CW    selects which PE y drives y_in (equals res_idx)
// y_in       in   W     selected PE result
// res_valid  out  1     result word available on res_data
// res_ready  in   1     consumer accepts res_data
// res_data   out  W     = y_in, combinationally forwarded
// res_idx    out  CW    index of the current result
// BEHAVIOUR
// - Reset (reset=0, any time, incl. mid-job): state=IDLE; every output and counter = 0.
//   Resumes in IDLE on release; an in-flight job is discarded with no done pulse.
// - States: IDLE, CLEAR, LOAD, COMPUTE, OUTPUT, DONE. One transition per clk max.
// - IDLE: start=1 -> CLEAR. Otherwise stay. start outside IDLE is ignored (no queueing).
// - CLEAR: pe_clr=1 for exactly 1 cycle -> LOAD.
// - LOAD: pe_load=1 for exactly 1 cycle; coef_addr=0 issued in this cycle; step=0
//   -> COMPUTE.
// - COMPUTE: lasts exactly N cycles, local cycle k = 0..N-1.
//   pe_en=1 every cycle.
//   coef_addr = k+1 for k < N-1; 0 on the last cycle (don't-care, held at 0).
//   After cycle N-1 -> OUTPUT with res_idx=0.
//   The coefficient for step k is always fetched 1 cycle before the pe_en that uses it.
// - OUTPUT: res_valid=1; y_sel=res_idx.
//   - On res_valid & res_ready:
//     - if res_idx = N-1 -> DONE;
//     - else res_idx += 1.
//   - res_ready low: hold res_idx/res_data; no timeout.
//   - res_valid never drops before its beat is accepted.
// - DONE: done=1 for 1 cycle, busy stays 1 -> IDLE; busy=0 in IDLE. A start in DONE
//   is ignored.
// - Counters wrap-free: step/res_idx never exceed N-1; a reset in COMPUTE or OUTPUT
//   clears them.
// - Outputs pe_clr/pe_load/pe_en/done/busy/res_valid are registered (decoded from
//   state flops); no combinational path from start or res_ready to any output except
//   res_data.
// - Latency, start accept to first res_valid: 1(CLEAR)+1(LOAD)+N(COMPUTE) = N+2
//   cycles. Total job with res_ready tied high: N+2+N+1 cycles.
// TESTING
// 1 Reset: hold reset=0 3 cycles with start=1 -> all outputs 0, state IDLE, no pe_* activity.
// 2 N=4, res_ready=1, start pulse at t0 -> clr@t0+1, load@t0+2, pe_en t0+3..t0+6,
//   coef_addr 0,1,2,3 at t0+2..t0+5, res_idx 0..3 at t0+7..t0+10, done@t0+11.
// 3 Backpressure: res_ready toggles 1,0,0,1,1,0,1 -> each index presented until accepted,
//   exactly 4 handshakes, res_data tracks y_in of y_sel.
// 4 Ignored start: start held high throughout job -> no restart until IDLE; new job
//   begins the cycle after DONE.
// 5 Reset mid-job: reset=0 during COMPUTE step 2 -> immediate IDLE, no done; next start
//   gives a clean full job.
// 6 Back-to-back: start=1 in the IDLE cycle right after done -> second job identical in
//   timing to test 2.

Source files
------------

// File: rtl/ring_sched.sv
// ring_sched: job sequencer for an N-element systolic ring of PEs computing y = A*x.
// Each job clears the PE accumulators, loads x_init, streams N coefficient steps,
// then drains the N results over a valid/ready port. Every control output is a pure
// decode of the state/counter flops. The only input-to-output path is y_in -> res_data.
module ring_sched #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pe_clr,
    output logic          pe_load,
    output logic          pe_en,
    output logic [CW-1:0] coef_addr,
    output logic [CW-1:0] y_sel,
    input  logic [W-1:0]  y_in,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic [CW-1:0] res_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [CW-1:0] res_idx_q, res_idx_d;

    // Next-state and counter update; one transition per cycle at most.
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        res_idx_d = res_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_COMPUTE;
                step_d  = '0;
            end
            S_COMPUTE: begin
                if (step_q == LAST) begin
                    state_d   = S_OUTPUT;
                    step_d    = '0;
                    res_idx_d = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                // The beat is accepted only when the consumer is ready.
                // res_valid is high for the whole state, so it is not re-tested here.
                if (res_ready) begin
                    if (res_idx_q == LAST) begin
                        state_d   = S_DONE;
                        res_idx_d = '0;
                    end else begin
                        res_idx_d = res_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                step_d    = '0;
                res_idx_d = '0;
            end
        endcase
    end

    // State and counter registers; an asynchronous reset abandons any job in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            res_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            res_idx_q <= res_idx_d;
        end
    end

    // Output decode from the flops only. The coefficient for step k is requested one
    // cycle ahead of its pe_en: address 0 in LOAD, then k+1 during COMPUTE, and 0 on
    // the final step.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        pe_clr    = 1'b0;
        pe_load   = 1'b0;
        pe_en     = 1'b0;
        res_valid = 1'b0;
        coef_addr = '0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CLEAR: begin
                busy   = 1'b1;
                pe_clr = 1'b1;
            end
            S_LOAD: begin
                busy      = 1'b1;
                pe_load   = 1'b1;
                coef_addr = '0;
            end
            S_COMPUTE: begin
                busy  = 1'b1;
                pe_en = 1'b1;
                if (step_q != LAST) coef_addr = step_q + 1'b1;
            end
            S_OUTPUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign res_idx  = res_idx_q;
    assign y_sel    = res_idx_q;
    assign res_data = y_in;

endmodule

// File: tb/tb_ring_sched.sv
// tb_ring_sched: randomized bench for ring_sched.
// The reference model describes a job as a timeline of cycle offsets counted from the
// accepting edge, plus a count of completed result handshakes.
// The PE array is modelled as a table of results indexed by y_sel.
module tb_ring_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 2;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          pe_clr;
        logic          pe_load;
        logic          pe_en;
        logic          res_valid;
        logic [CW-1:0] coef_addr;
        logic [CW-1:0] y_sel;
        logic [CW-1:0] res_idx;
        logic [W-1:0]  res_data;
    } out_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, pe_clr, pe_load, pe_en, res_valid;
    logic [CW-1:0] coef_addr, y_sel, res_idx;
    logic [W-1:0]  y_in, res_data;
    logic          res_ready;
    logic [W-1:0]  y_mem [N];

    ring_sched #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pe_clr(pe_clr), .pe_load(pe_load), .pe_en(pe_en), .coef_addr(coef_addr),
        .y_sel(y_sel), .y_in(y_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    assign y_in = y_mem[y_sel];

    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           hs_count = 0;
    bit           m_active = 1'b0;
    int           m_off = 0;
    int           m_hs = 0;
    out_t         exp_o, obs_o;
    logic [W-1:0] got_q [$];

    function automatic out_t sample();
        out_t o;
        o.busy = busy; o.done = done; o.pe_clr = pe_clr; o.pe_load = pe_load;
        o.pe_en = pe_en; o.res_valid = res_valid; o.coef_addr = coef_addr;
        o.y_sel = y_sel; o.res_idx = res_idx; o.res_data = res_data;
        return o;
    endfunction

    task automatic new_data();
        for (int i = 0; i < N; i++) y_mem[i] = W'($urandom);
    endtask

    // Expected outputs for the current cycle from the job timeline.
    task automatic compute_exp();
        exp_o = '0;
        exp_o.res_data = y_mem[0];
        if (m_active) begin
            exp_o.busy = 1'b1;
            if (m_off == 1) begin
                exp_o.pe_clr = 1'b1;
            end else if (m_off == 2) begin
                exp_o.pe_load = 1'b1;
            end else if (m_off <= N + 2) begin
                exp_o.pe_en = 1'b1;
                exp_o.coef_addr = CW'((m_off - 2 < N) ? m_off - 2 : 0);
            end else if (m_hs < N) begin
                exp_o.res_valid = 1'b1;
                exp_o.res_idx   = CW'(m_hs);
                exp_o.y_sel     = CW'(m_hs);
                exp_o.res_data  = y_mem[m_hs];
            end else begin
                exp_o.done = 1'b1;
            end
        end
    endtask

    // Drive one cycle's inputs mid-cycle, then form the expectation.
    task automatic apply(input logic st, input logic rdy);
        @(negedge clk);
        start = st;
        res_ready = rdy;
        #1;
        cyc++;
        compute_exp();
    endtask

    // Advance the model across the coming rising edge.
    task automatic advance();
        if (!reset) begin
            m_active = 1'b0; m_off = 0; m_hs = 0;
        end else if (m_active) begin
            if (m_off >= N + 3 && m_hs < N) begin
                if (res_ready) begin
                    got_q.push_back(res_data);
                    hs_count++;
                    m_hs++;
                end
            end else if (m_off >= N + 3) begin
                m_active = 1'b0;
            end
            m_off++;
        end else if (start) begin
            m_active = 1'b1; m_off = 1; m_hs = 0;
            got_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            advance();
        end
        start = 1'b0;
        reset = 1'b1;
        apply(1'b0, 1'b1);
        obs_o = sample(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++;
            $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
        end
        advance();
    endtask

    task automatic test_nominal(input string tag);
        int t0, done_cyc;
        done_cyc = -1;
        new_data();
        apply(1'b1, 1'b1);
        t0 = cyc;
        obs_o = sample(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs_o, exp_o);
        end
        advance();
        for (int k = 0; k < 40 && m_active; k++) begin
            apply(1'b0, 1'b1);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs_o, exp_o);
            end
            if (done === 1'b1) done_cyc = cyc;
            advance();
        end
        vectors++;
        if (done_cyc != t0 + 2 * N + 3) begin
            miscompares++;
            $display("FAIL %s_done_time got=%0d want=%0d", tag, done_cyc - t0, 2 * N + 3);
        end
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] g;
            g = (i < got_q.size()) ? got_q[i] : 'x;
            vectors++;
            if (g !== y_mem[i]) begin
                miscompares++;
                $display("FAIL %s_result%0d got=%h want=%h", tag, i, g, y_mem[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int oi;
        logic rdy;
        oi = 0;
        hs_count = 0;
        new_data();
        apply(1'b1, 1'b0);
        advance();
        for (int k = 0; k < 40 && m_active; k++) begin
            if (m_off >= N + 3 && m_hs < N) begin
                rdy = (oi < 7) ? pat[oi][0] : 1'b1;
                oi++;
            end else begin
                rdy = 1'($urandom);
            end
            apply(1'b0, rdy);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            advance();
        end
        vectors++;
        if (hs_count != N || m_active) begin
            miscompares++;
            $display("FAIL backpressure_handshakes got=%0d want=%0d", hs_count, N);
        end
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] g;
            g = (i < got_q.size()) ? got_q[i] : 'x;
            vectors++;
            if (g !== y_mem[i]) begin
                miscompares++;
                $display("FAIL backpressure_result%0d got=%h want=%h", i, g, y_mem[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int done_cyc;
        done_cyc = -1;
        new_data();
        for (int k = 0; k < 60 && done_cyc < 0; k++) begin
            apply(1'b1, $urandom_range(0, 3) != 0);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL ignored_start cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            if (done === 1'b1) done_cyc = cyc;
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 1'b1);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL ignored_start_restart cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            advance();
        end
        vectors++;
        if (pe_clr !== 1'b1 || cyc != done_cyc + 2) begin
            miscompares++;
            $display("FAIL ignored_start_clr got=%0d want=%0d", cyc - done_cyc, 2);
        end
        for (int k = 0; k < 40 && m_active; k++) begin
            apply(1'b0, 1'b1);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL ignored_start_tail cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        new_data();
        apply(1'b1, 1'b1);
        advance();
        for (int k = 0; k < 20 && m_off != 5; k++) begin
            apply(1'b0, 1'b1);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            if (m_off != 5) advance();
        end
        reset = 1'b0;
        #1;
        advance();
        compute_exp();
        obs_o = sample(); vectors++;
        if (obs_o !== exp_o) begin
            miscompares++;
            $display("FAIL reset_mid_async cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
        end
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b1);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL reset_mid_hold cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            advance();
        end
        reset = 1'b1;
        test_nominal("reset_mid_rerun");
    endtask

    task automatic test_back_to_back();
        test_nominal("b2b_first");
        test_nominal("b2b_second");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if (!m_active) new_data();
            apply($urandom_range(0, 4) == 0, $urandom_range(0, 4) < 3);
            obs_o = sample(); vectors++;
            if (obs_o !== exp_o) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_o, exp_o);
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        new_data();
        #2;
        test_reset();
        test_nominal("nominal");
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
